pulse_cmd_buffer: RTL and testbench



---
 rtl/pulse_cmd_buffer.sv | 130 +++++++++++++
 tb/tb_pulse_cmd_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_cmd_buffer.sv
// pulse_cmd_buffer
//   Elastic FIFO between the processor pulse command port and the
//   signal-generator element. Each strobed command is queued and presented
//   in order over a valid/ready handshake; cfg is split into mode and dest.
//   Commands arriving while full (with no pop in the same cycle) are dropped
//   and flagged on the sticky overflow output.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   phase/freq/amp/env_word   command fields, captured on cstrobe
//   cfg                       command cfg: [1:0] mode, [CFG_WIDTH-1:2] dest
//   cstrobe                   single-cycle command valid, no back-pressure
//   cmd_reset                 synchronous flush (pointers, level, overflow)
//   out_*                     head-entry fields
//   out_valid / out_ready     head handshake toward the element
//   level, full               occupancy
//   overflow, overflow_clr    sticky drop flag and its clear
//
// Build option
//   PULSE_CMD_BUF_STATS_EN    adds saturating accepted_cnt / dropped_cnt outputs

module pulse_cmd_buffer #(
  parameter int PHASE_WIDTH    = 17,
  parameter int FREQ_WIDTH     = 9,
  parameter int AMP_WIDTH      = 16,
  parameter int CFG_WIDTH      = 4,
  parameter int ENV_WORD_WIDTH = 24,
  parameter int DEPTH          = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [PHASE_WIDTH-1:0]    phase,
  input  logic [FREQ_WIDTH-1:0]     freq,
  input  logic [AMP_WIDTH-1:0]      amp,
  input  logic [ENV_WORD_WIDTH-1:0] env_word,
  input  logic [CFG_WIDTH-1:0]      cfg,
  input  logic                      cstrobe,
  input  logic                      cmd_reset,
  output logic [PHASE_WIDTH-1:0]    out_phase,
  output logic [FREQ_WIDTH-1:0]     out_freq,
  output logic [AMP_WIDTH-1:0]      out_amp,
  output logic [ENV_WORD_WIDTH-1:0] out_env_word,
  output logic [1:0]                out_mode,
  output logic [CFG_WIDTH-3:0]      out_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      overflow,
`ifdef PULSE_CMD_BUF_STATS_EN
  output logic [15:0]               accepted_cnt,
  output logic [15:0]               dropped_cnt,
`endif
  input  logic                      overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = PHASE_WIDTH + FREQ_WIDTH + AMP_WIDTH + ENV_WORD_WIDTH + CFG_WIDTH;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level_q;
  logic [EW-1:0]  head;
  logic           pop;
  logic           push;
  logic           drop;

  assign out_valid = (level_q != '0);
  assign full      = (level_q == LVL_FULL);
  assign level     = level_q;

  // A flush masks every other request in its cycle.
  assign pop  = out_valid & out_ready & ~cmd_reset;
  assign push = cstrobe & (~full | pop) & ~cmd_reset;
  assign drop = cstrobe & full & ~pop & ~cmd_reset;

  // Storage is intentionally not reset or flushed; only bookkeeping is.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {phase, freq, amp, env_word, cfg};
  end

  assign head         = mem[rd_ptr];
  assign out_phase    = head[EW-1 -: PHASE_WIDTH];
  assign out_freq     = head[EW-PHASE_WIDTH-1 -: FREQ_WIDTH];
  assign out_amp      = head[ENV_WORD_WIDTH+CFG_WIDTH+AMP_WIDTH-1 -: AMP_WIDTH];
  assign out_env_word = head[ENV_WORD_WIDTH+CFG_WIDTH-1 -: ENV_WORD_WIDTH];
  assign out_dest     = head[CFG_WIDTH-1:2];
  assign out_mode     = head[1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else if (cmd_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

`ifdef PULSE_CMD_BUF_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      accepted_cnt <= '0;
      dropped_cnt  <= '0;
    end else if (cmd_reset) begin
      accepted_cnt <= '0;
      dropped_cnt  <= '0;
    end else begin
      if (push && accepted_cnt != 16'hFFFF) accepted_cnt <= accepted_cnt + 16'd1;
      if (drop && dropped_cnt != 16'hFFFF)  dropped_cnt  <= dropped_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_cmd_buffer.sv
// Testbench for pulse_cmd_buffer (default parameters, DEPTH=8).
// Table-driven vectors plus hand-written corner sequences; popped data is
// checked against a queue of expected commands filled as stimulus is driven.

module tb_pulse_cmd_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic [16:0] phase;
  logic [8:0]  freq;
  logic [15:0] amp;
  logic [23:0] env_word;
  logic [3:0]  cfg;
  logic        cstrobe, cmd_reset, out_ready, overflow_clr;
  logic [16:0] out_phase;
  logic [8:0]  out_freq;
  logic [15:0] out_amp;
  logic [23:0] out_env_word;
  logic [1:0]  out_mode;
  logic [1:0]  out_dest;
  logic        out_valid, full, overflow;
  logic [3:0]  level;
`ifdef PULSE_CMD_BUF_STATS_EN
  logic [15:0] accepted_cnt, dropped_cnt;
`endif

  pulse_cmd_buffer dut (
    .clk(clk), .rstn(rstn),
    .phase(phase), .freq(freq), .amp(amp), .env_word(env_word), .cfg(cfg),
    .cstrobe(cstrobe), .cmd_reset(cmd_reset),
    .out_phase(out_phase), .out_freq(out_freq), .out_amp(out_amp),
    .out_env_word(out_env_word), .out_mode(out_mode), .out_dest(out_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .full(full), .overflow(overflow),
`ifdef PULSE_CMD_BUF_STATS_EN
    .accepted_cnt(accepted_cnt), .dropped_cnt(dropped_cnt),
`endif
    .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [69:0] sb[$];
  int          mdl_level = 0;
  logic        mdl_ovf   = 1'b0;
  int          mdl_acc   = 0;
  int          mdl_drop  = 0;

  typedef struct {
    logic        s;
    logic        r;
    logic        c;
    logic [16:0] ph;
    logic [3:0]  cf;
    int          lvl;
    logic        v;
    logic        f;
    logic        o;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [69:0] make_rec(input logic [16:0] ph, input logic [3:0] cf);
    logic [8:0]  fq;
    logic [15:0] am;
    logic [23:0] ev;
    fq = ph[8:0] ^ 9'h155;
    am = ph[15:0] ^ 16'h5A3C;
    ev = {ph[11:0], ~ph[11:0]};
    return {ph, fq, am, ev, cf};
  endfunction

  // One clock: drive inputs, score a predicted pop, advance, check state.
  task automatic cyc(input logic s, input logic r, input logic c, input logic fl,
                     input logic [16:0] ph, input logic [3:0] cf);
    logic [69:0] rec;
    logic        p, pu, dr;
    rec = make_rec(ph, cf);
    {phase, freq, amp, env_word, cfg} = rec;
    cstrobe = s; out_ready = r; overflow_clr = c; cmd_reset = fl;
    p  = !fl && (mdl_level != 0) && r;
    pu = !fl && s && (mdl_level < 8 || p);
    dr = !fl && s && (mdl_level == 8) && !p;
    if (fl) begin
      sb.delete();
      mdl_level = 0; mdl_ovf = 1'b0; mdl_acc = 0; mdl_drop = 0;
    end else begin
      if (p) begin
        if (sb.size() == 0) chk("pop_underflow", 96'd1, 96'd0);
        else chk("pop_data", {26'd0, out_phase, out_freq, out_amp, out_env_word, out_dest, out_mode},
                 {26'd0, sb.pop_front()});
      end
      if (pu) sb.push_back(rec);
      mdl_level = mdl_level + (pu ? 1 : 0) - (p ? 1 : 0);
      if (dr) mdl_ovf = 1'b1;
      else if (c) mdl_ovf = 1'b0;
      if (pu) mdl_acc++;
      if (dr) mdl_drop++;
    end
    @(posedge clk);
    #1;
    chk("level", 96'(level), 96'(mdl_level));
    chk("out_valid", 96'(out_valid), 96'(mdl_level != 0));
    chk("full", 96'(full), 96'(mdl_level == 8));
    chk("overflow", 96'(overflow), 96'(mdl_ovf));
`ifdef PULSE_CMD_BUF_STATS_EN
    chk("accepted_cnt", 96'(accepted_cnt), 96'(mdl_acc));
    chk("dropped_cnt", 96'(dropped_cnt), 96'(mdl_drop));
`endif
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, 17'(i + 1), 4'(i + 1), i + 1, 1'b1, (i == 7), 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 17'd9,  4'd9,  8, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 17'd10, 4'd10, 8, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 17'd0,  4'd0,  8, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[11 + i] = '{1'b0, 1'b1, 1'b0, 17'd0, 4'd0, 7 - i, (i != 7), 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 17'd21, 4'b1101, 1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++)
      tbl[20 + i] = '{1'b1, 1'b1, 1'b0, 17'(22 + i), 4'b1101, 1, 1'b1, 1'b0, 1'b0};
    tbl[24] = '{1'b0, 1'b1, 1'b0, 17'd0, 4'b1101, 0, 1'b0, 1'b0, 1'b0};

    rstn = 1'b0;
    {phase, freq, amp, env_word, cfg} = '0;
    cstrobe = 1'b0; cmd_reset = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 96'(level), 96'd0);
    chk("rst_valid", 96'(out_valid), 96'd0);
    chk("rst_full", 96'(full), 96'd0);
    chk("rst_overflow", 96'(overflow), 96'd0);
    rstn = 1'b1;

    // Fill/drop, overflow set/clear collision, drain, then in-order stream.
    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].s, tbl[i].r, tbl[i].c, 1'b0, tbl[i].ph, tbl[i].cf);
      chk("tbl_level", 96'(level), 96'(tbl[i].lvl));
      chk("tbl_valid", 96'(out_valid), 96'(tbl[i].v));
      chk("tbl_full", 96'(full), 96'(tbl[i].f));
      chk("tbl_overflow", 96'(overflow), 96'(tbl[i].o));
      if (i >= 19 && i < 24) begin
        chk("tbl_mode", 96'(out_mode), 96'(2'b01));
        chk("tbl_dest", 96'(out_dest), 96'(2'b11));
      end
    end

    // Full with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 17'(100 + i), 4'(i));
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 17'(200 + i), 4'(i));
      chk("full_pp_level", 96'(level), 96'd8);
      chk("full_pp_overflow", 96'(overflow), 96'd0);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 17'd0, 4'd0);

    // Flush priority over strobe, clear and pop at level 4 with overflow set.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 17'(300 + i), 4'(i));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 17'd399, 4'd3);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 17'd0, 4'd0);
    chk("pre_flush_level", 96'(level), 96'd4);
    chk("pre_flush_overflow", 96'(overflow), 96'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 17'd500, 4'd5);
    chk("flush_level", 96'(level), 96'd0);
    chk("flush_valid", 96'(out_valid), 96'd0);
    chk("flush_overflow", 96'(overflow), 96'd0);
`ifdef PULSE_CMD_BUF_STATS_EN
    chk("flush_accepted", 96'(accepted_cnt), 96'd0);
    chk("flush_dropped", 96'(dropped_cnt), 96'd0);
`endif
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 17'd0, 4'd0);
    chk("post_flush_valid", 96'(out_valid), 96'd0);

    // Stats after 9 strobes into an empty buffer, then async reset at level 3.
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 17'(600 + i), 4'(i));
`ifdef PULSE_CMD_BUF_STATS_EN
    chk("stats_accepted", 96'(accepted_cnt), 96'd8);
    chk("stats_dropped", 96'(dropped_cnt), 96'd1);
`endif
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 17'd0, 4'd0);
    chk("pre_rst_level", 96'(level), 96'd3);
    rstn = 1'b0;
    #2;
    chk("async_rst_level", 96'(level), 96'd0);
    chk("async_rst_valid", 96'(out_valid), 96'd0);
    chk("async_rst_overflow", 96'(overflow), 96'd0);
    sb.delete();
    mdl_level = 0; mdl_ovf = 1'b0; mdl_acc = 0; mdl_drop = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 17'd0, 4'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 17'd700, 4'hE);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 17'd0, 4'd0);
    chk("final_sb_empty", 96'(sb.size()), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
